spiflash_fw_port: RTL and testbench
===================================

# spiflash_fw_port

Firmware fetch bridge between the SoC's firmware port (`fw_addr`/`fw_valid`/`fw_ready`/`fw_rdata`) and an external SPI NOR flash. It translates 32-bit word fetches into standard-read (0x03) SPI transactions. Sequential fetches are served by continuing the open read burst instead of re-issuing a command. It sits directly upstream of the SoC's `fw_*` inputs and is the only master of the flash pins.

## Interface

Parameters:
- `FLASH_BASE`, default 24'h100000: flash byte offset of firmware word 0.
- `CLK_DIV`, default 1: SCK half-period in `clk` cycles. Legal range is 1..255.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high.
- `fw_addr`, input, 16: firmware word address.
- `fw_valid`, input, 1: fetch request. Held high by the master until `fw_ready`.
- `fw_ready`, output, 1: one-cycle response strobe.
- `fw_rdata`, output, 32: fetched word. Valid when `fw_ready`=1.
- `flash_csb`, output, 1: flash chip select, active-low.
- `flash_clk`, output, 1: SCK, SPI mode 0.
- `flash_mosi`, output, 1: serial data to flash.
- `flash_miso`, input, 1: serial data from flash.

## Operation

- Flash byte address = (`FLASH_BASE` + {`fw_addr`,2'b00}) mod 2^24.
- Bytes are little-endian: the first received byte goes to `fw_rdata[7:0]`. Bits within a byte are MSB-first.
- States:
  - WAKE: after reset, send 0xAB (8 bits) with `csb`=0. Then go to GAP.
  - GAP: `csb`=1 for 2·CLK_DIV cycles. Then go to IDLE.
  - IDLE: `csb`=1. On `fw_valid`, latch the address and go to CMD.
  - CMD: shift out 0x03 followed by the 24-bit address (32 bits). Then go to DATA.
  - DATA: shift in 32 bits. Then go to DONE.
  - DONE: `fw_ready`=1 for exactly one cycle. `last_addr` ← `fw_addr`. Then go to HOLD.
  - HOLD: `csb` stays 0.
    - `fw_valid` is ignored in the first HOLD cycle.
    - After that, on `fw_valid` with `fw_addr` == `last_addr`+1 (16-bit, no wrap), go to DATA. This is the streaming path.
    - On `fw_valid` with any other address, go to GAP and then CMD. The request stays latched; IDLE is not revisited.
- `fw_addr` 16'hFFFF followed by 16'h0000 is non-sequential.
- Requests arriving during WAKE/GAP are held. They are served after GAP, and `fw_ready` stays 0 until then.
- `fw_ready` is never asserted outside DONE. `fw_rdata` holds its value between strobes.
- Reset mid-transaction:
  - next cycle `csb`=1, `flash_clk`=0, `fw_ready`=0;
  - the transfer is aborted and the WAKE sequence restarts.
- Reset values: `flash_csb`=1, `flash_clk`=0, `flash_mosi`=0, `fw_ready`=0, `fw_rdata`=0, `last_addr` invalid.

## Timing

- SPI mode 0:
  - `flash_clk` idles low;
  - each bit is CLK_DIV cycles low, then CLK_DIV cycles high;
  - MOSI is updated at the start of the low phase;
  - MISO is sampled on the cycle `flash_clk` rises.
- `csb` falls in the cycle after the decision to start. The first SCK low phase begins in that same cycle.
- Let T be the cycle in which `fw_valid` is sampled.
- Miss from IDLE: `fw_ready` is high in cycle T+1+128·CLK_DIV.
  - With CLK_DIV=1 this is T+129.
- Sequential hit in HOLD: `fw_ready` is high in cycle T+1+64·CLK_DIV.
  - With CLK_DIV=1 this is T+65.
- Non-sequential in HOLD: `fw_ready` is high in cycle T+1+2·CLK_DIV+128·CLK_DIV.
- `flash_clk` is 0 whenever `csb` changes. No SCK edges occur in DONE or HOLD.

## Structure

- Package `spiflash_fw_pkg` holds:
  - the state enum (WAKE, GAP, IDLE, CMD, DATA, DONE, HOLD);
  - constants CMD_READ=8'h03 and CMD_WAKE=8'hAB;
  - bit counts CMD_BITS=32, DATA_BITS=32, WAKE_BITS=8.
- Sub-module `spi_shift_engine` owns:
  - the SCK divider;
  - a 32-bit TX/RX shift register;
  - the bit counter.
- It is started with `start`, `nbits` and `txdata`, and returns `done` and `rxdata`.
- The top level holds the FSM, address latch, `last_addr` and the byte-swap.

## Test plan

- Reset, then idle with no request → 0xAB observed on MOSI with `csb` low for 8 SCKs. After that `csb`=1 and `fw_ready` stays 0.
- `fw_addr`=16'h0000, flash model holds bytes 13 00 00 00 at 0x100000, CLK_DIV=1 → MOSI shows 03 10 00 00. `fw_rdata`=32'h00000013 with `fw_ready` at T+129, exactly one cycle.
- Fetch 16'h0004, then 16'h0005 → the second fetch has no new command, `csb` stays low, and it completes at T+65 with the bytes from 0x100014.
- Fetch 16'h0005, then 16'h0002 → `csb` high for 2 cycles, new command 03 10 00 08, completes at T+131.
- Fetch 16'hFFFF, then 16'h0000 → treated as non-sequential. The new command carries address 0x100000.
- Assert `reset` during DATA bit 20 → next cycle `csb`=1, `flash_clk`=0, `fw_ready`=0. The WAKE sequence then repeats, and the held request completes afterwards with correct data.

Source files
------------

// File: rtl/spiflash_fw_pkg.sv
// Shared types and constants for the firmware-fetch SPI flash bridge.
package spiflash_fw_pkg;

    typedef enum logic [2:0] {WAKE, GAP, IDLE, CMD, DATA, DONE, HOLD} state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WAKE  = 8'hAB;
    localparam logic [5:0] CMD_BITS  = 6'd32;
    localparam logic [5:0] DATA_BITS = 6'd32;
    localparam logic [5:0] WAKE_BITS = 6'd8;

    // Flash streams bytes in address order; firmware expects little-endian words.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shifter: SCK divider, shared 32-bit TX/RX shift register, bit counter.
module spi_shift_engine
    import spiflash_fw_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  nbits,
    input  logic [31:0] txdata,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        done,
    output logic [31:0] rxdata
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic        busy;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] sh;
    logic        miso_q;
    logic        phase_end;
    logic        rx_bit;

    assign phase_end = busy && (div_cnt == LAST);
    // With CLK_DIV=1 the sampling cycle is also the shifting cycle, so take MISO live.
    assign rx_bit    = (div_cnt == 8'd0) ? miso : miso_q;
    assign done      = phase_end && sck && (bit_cnt == 6'd0);
    assign rxdata    = {sh[30:0], rx_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            miso_q  <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            sck     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= nbits - 6'd1;
            sh      <= txdata;
            mosi    <= txdata[31];
        end else if (busy) begin
            if (sck && div_cnt == 8'd0)
                miso_q <= miso;
            if (phase_end) begin
                div_cnt <= '0;
                if (!sck) begin
                    sck <= 1'b1;
                end else begin
                    sck <= 1'b0;
                    sh  <= {sh[30:0], rx_bit};
                    if (bit_cnt == 6'd0) begin
                        busy <= 1'b0;
                        mosi <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 6'd1;
                        mosi    <= sh[30];
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/spiflash_fw_port.sv
// Firmware word fetch over SPI NOR standard read, keeping the burst open for sequential fetches.
module spiflash_fw_port
    import spiflash_fw_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h100000,
    parameter int          CLK_DIV    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] fw_addr,
    input  logic        fw_valid,
    output logic        fw_ready,
    output logic [31:0] fw_rdata,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

    state_t      state;
    logic [15:0] addr_q;
    logic [15:0] last_addr;
    logic        last_vld;
    logic        woke;
    logic        pending;
    logic        hold_first;
    logic [8:0]  gap_cnt;

    logic        eng_start;
    logic        eng_done;
    logic [5:0]  eng_nbits;
    logic [31:0] eng_tx;
    logic [31:0] eng_rx;
    logic        gap_done;
    logic        seq_hit;

    function automatic logic [31:0] read_cmd(input logic [15:0] a);
        return {CMD_READ, FLASH_BASE + {6'b0, a, 2'b00}};
    endfunction

    assign gap_done = (gap_cnt == GAP_LAST);
    // 16'hFFFF -> 16'h0000 deliberately breaks the stream: the flash address would not wrap with it.
    assign seq_hit  = last_vld && (last_addr != 16'hFFFF) && (fw_addr == last_addr + 16'd1);

    // Engine launches in the decision cycle so CSB fall and the first SCK low phase coincide.
    always_comb begin
        eng_start = 1'b0;
        eng_nbits = DATA_BITS;
        eng_tx    = '0;
        case (state)
            WAKE: begin
                eng_start = !woke;
                eng_nbits = WAKE_BITS;
                eng_tx    = {CMD_WAKE, 24'h0};
            end
            GAP: begin
                eng_start = gap_done && pending;
                eng_nbits = CMD_BITS;
                eng_tx    = read_cmd(addr_q);
            end
            IDLE: begin
                eng_start = fw_valid;
                eng_nbits = CMD_BITS;
                eng_tx    = read_cmd(fw_addr);
            end
            CMD:     eng_start = eng_done;
            HOLD:    eng_start = !hold_first && fw_valid && seq_hit;
            default: eng_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAKE;
            woke       <= 1'b0;
            pending    <= 1'b0;
            hold_first <= 1'b0;
            gap_cnt    <= '0;
            addr_q     <= '0;
            last_addr  <= '0;
            last_vld   <= 1'b0;
            flash_csb  <= 1'b1;
            fw_ready   <= 1'b0;
            fw_rdata   <= '0;
        end else begin
            fw_ready <= 1'b0;
            case (state)
                WAKE: begin
                    if (!woke) begin
                        woke      <= 1'b1;
                        flash_csb <= 1'b0;
                    end else if (eng_done) begin
                        flash_csb <= 1'b1;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (pending) begin
                            pending   <= 1'b0;
                            flash_csb <= 1'b0;
                            state     <= CMD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 9'd1;
                    end
                end
                IDLE: begin
                    if (fw_valid) begin
                        addr_q    <= fw_addr;
                        flash_csb <= 1'b0;
                        state     <= CMD;
                    end
                end
                CMD: if (eng_done) state <= DATA;
                DATA: begin
                    if (eng_done) begin
                        fw_ready <= 1'b1;
                        fw_rdata <= bswap32(eng_rx);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    last_addr  <= addr_q;
                    last_vld   <= 1'b1;
                    hold_first <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    // The master may still be dropping the previous request in the first HOLD cycle.
                    if (hold_first) begin
                        hold_first <= 1'b0;
                    end else if (fw_valid) begin
                        addr_q <= fw_addr;
                        if (seq_hit) begin
                            state <= DATA;
                        end else begin
                            pending   <= 1'b1;
                            flash_csb <= 1'b1;
                            gap_cnt   <= '0;
                            state     <= GAP;
                        end
                    end
                end
                default: state <= WAKE;
            endcase
        end
    end

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_eng (
        .clk    (clk),
        .reset  (reset),
        .start  (eng_start),
        .nbits  (eng_nbits),
        .txdata (eng_tx),
        .miso   (flash_miso),
        .sck    (flash_clk),
        .mosi   (flash_mosi),
        .done   (eng_done),
        .rxdata (eng_rx)
    );

endmodule

// File: tb/tb_spiflash_fw_port.sv
// Scoreboard bench for spiflash_fw_port with a behavioural SPI NOR flash model.
module tb_spiflash_fw_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] fw_addr;
    logic        fw_valid;
    logic        fw_ready;
    logic [31:0] fw_rdata;
    logic        flash_csb;
    logic        flash_clk;
    logic        flash_mosi;
    logic        flash_miso = 1'b0;

    spiflash_fw_port #(.FLASH_BASE(24'h100000), .CLK_DIV(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .fw_addr    (fw_addr),
        .fw_valid   (fw_valid),
        .fw_ready   (fw_ready),
        .fw_rdata   (fw_rdata),
        .flash_csb  (flash_csb),
        .flash_clk  (flash_clk),
        .flash_mosi (flash_mosi),
        .flash_miso (flash_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Flash contents: a fixed word at the firmware base, hashed bytes elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h100000) return 8'h13;
        if (a >= 24'h100001 && a <= 24'h100003) return 8'h00;
        return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [23:0] flash_of(input logic [15:0] a);
        return 24'h100000 + {6'b0, a, 2'b00};
    endfunction

    function automatic logic [31:0] exp_word(input logic [15:0] a);
        logic [23:0] b;
        b = flash_of(a);
        return {mem_byte(b + 24'd3), mem_byte(b + 24'd2), mem_byte(b + 24'd1), mem_byte(b)};
    endfunction

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t        sb[$];
    logic [23:0] cmdq[$];

    // ---------------- flash model ----------------
    int          fl_bits = 0;
    logic [31:0] fl_sh = '0;
    logic [23:0] fl_addr = '0;
    int          wakes = 0;

    always @(negedge flash_csb) begin
        fl_bits = 0;
        fl_sh   = '0;
    end

    always @(posedge flash_clk) if (flash_csb === 1'b0) begin
        fl_sh = {fl_sh[30:0], flash_mosi};
        fl_bits++;
        if (fl_bits == 32) begin
            chk("cmd_expected", cmdq.size() > 0, 1);
            if (cmdq.size() > 0) begin
                logic [23:0] e;
                e = cmdq.pop_front();
                chk("cmd_opcode", fl_sh[31:24], 8'h03);
                chk("cmd_addr", fl_sh[23:0], e);
            end
            fl_addr = fl_sh[23:0];
        end
    end

    always @(negedge flash_clk) if (flash_csb === 1'b0 && fl_bits >= 32) begin
        int          idx;
        logic [7:0]  b;
        idx = fl_bits - 32;
        b = mem_byte(fl_addr + 24'(idx / 8));
        flash_miso = b[7 - (idx % 8)];
    end

    always @(posedge flash_csb) if (fl_bits == 8) begin
        wakes++;
        chk("wake_byte", fl_sh[7:0], 8'hAB);
    end

    // ---------------- monitor ----------------
    logic        rdy_prev = 1'b0;
    logic [31:0] data_prev = '0;

    always @(negedge clk) if (reset === 1'b0) begin
        if (rdy_prev) begin
            chk("ready_one_cycle", fw_ready, 0);
            chk("rdata_hold", fw_rdata, data_prev);
        end
        if (fw_ready === 1'b1) begin
            chk("ready_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", fw_rdata, e.d);
                if (e.c >= 0) chk("ready_cycle", cyc, e.c);
            end
        end
        rdy_prev  = fw_ready;
        data_prev = fw_rdata;
    end else begin
        rdy_prev = 1'b0;
    end

    // ---------------- driver + reference model ----------------
    logic        in_hold = 1'b0;
    logic [15:0] last_a = '0;

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fw_ready !== 1'b1 && n < limit);
        chk("ready_seen", fw_ready, 1);
    endtask

    // Called just after a rising edge; k idle cycles precede the request.
    task automatic fetch(input logic [15:0] a, input int k);
        logic seq, csb_rose;
        int   t, lat, n;
        seq = in_hold && (last_a != 16'hFFFF) && (a == last_a + 16'd1);
        repeat (k) begin
            fw_valid = 1'b0;
            @(posedge clk); #1;
        end
        t   = cyc + ((k == 0 && in_hold) ? 1 : 0);
        lat = !in_hold ? 129 : (seq ? 65 : 131);
        fw_addr  = a;
        fw_valid = 1'b1;
        sb.push_back('{exp_word(a), t + lat});
        if (!seq) cmdq.push_back(flash_of(a));
        n = 0;
        csb_rose = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (flash_csb) csb_rose = 1'b1;
        end while (fw_ready !== 1'b1 && n < 400);
        chk("ready_seen", fw_ready, 1);
        if (seq) chk("stream_csb_low", csb_rose, 0);
        in_hold = 1'b1;
        last_a  = a;
        @(posedge clk); #1;
        fw_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        int          t;
        reset    = 1'b1;
        fw_valid = 1'b0;
        fw_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_csb", flash_csb, 1);
        chk("rst_sck", flash_clk, 0);
        chk("rst_mosi", flash_mosi, 0);
        chk("rst_ready", fw_ready, 0);
        chk("rst_rdata", fw_rdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Wake sequence with no traffic.
        repeat (40) @(posedge clk);
        #1;
        chk("wake_count", wakes, 1);
        chk("idle_csb", flash_csb, 1);

        // Directed cases.
        fetch(16'h0000, 1);
        fetch(16'h0004, 2);
        fetch(16'h0005, 0);
        fetch(16'h0002, 1);
        fetch(16'hFFFF, 3);
        fetch(16'h0000, 0);
        fetch(16'h0001, 1);

        // Randomized mix of streaming and jumping fetches.
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)      a = last_a + 16'd1;
            else if (r == 5) a = 16'hFFFF;
            else            a = 16'($urandom);
            fetch(a, $urandom_range(0, 3));
        end

        // Reset during DATA bit 20 of a non-sequential fetch; the request stays held.
        @(posedge clk); #1;
        a = last_a + 16'd7;
        fw_addr  = a;
        fw_valid = 1'b1;
        t = cyc;
        cmdq.push_back(flash_of(a));
        while (cyc < t + 107) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_csb", flash_csb, 1);
        chk("abort_sck", flash_clk, 0);
        chk("abort_ready", fw_ready, 0);
        chk("abort_rdata", fw_rdata, 0);
        in_hold = 1'b0;
        sb.push_back('{exp_word(a), -1});
        cmdq.push_back(flash_of(a));
        wait_ready(600);
        @(posedge clk); #1;
        fw_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        chk("cmdq_drained", cmdq.size(), 0);
        chk("wake_count_final", wakes, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
